// File: rtl/ysyx_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_ifu_fetch
// Brief    : Instruction fetch unit. Owns the fetch PC, issues credit-limited
//            requests to instruction memory and buffers responses in a FIFO.
//            Optional macro YSYX_IFU_MISALIGN_EN halts fetch on a misaligned
//            target.
// Revision : 1.0
// ============================================================================
module ysyx_ifu_fetch #(
   parameter int              XLEN     = 32,
   parameter int              ILEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [ILEN-1:0] imem_rsp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [ILEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc,
   output logic            misalign
);
   localparam int              AW      = $clog2(DEPTH);
   localparam int              CW      = $clog2(DEPTH) + 1;
   localparam logic [CW:0]     CREDITS = (CW+1)'(DEPTH);
   localparam logic [XLEN-1:0] STEP    = XLEN'(4);

   logic [XLEN-1:0] fpc;
   logic [XLEN-1:0] rpc;
   logic [CW-1:0]   count;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   outstanding_nxt;
   logic [CW-1:0]   drop;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [ILEN-1:0] fifo_inst [DEPTH];
   logic [XLEN-1:0] fifo_pc   [DEPTH];
   logic [CW:0]     in_use;
   logic            halted;
   logic            req_fire;
   logic            push;
   logic            pop;

   // Every in-flight request already owns a FIFO slot, so a kept response can never overflow.
   assign in_use          = {1'b0, count} + {1'b0, outstanding};
   assign imem_req_valid  = rst && !redirect && !halted && (in_use < CREDITS);
   assign imem_req_addr   = fpc;
   assign req_fire        = imem_req_valid && imem_req_ready;
   assign push            = rst && !redirect && imem_rsp_valid && (drop == '0);
   assign inst_valid      = rst && (count != '0);
   assign pop             = inst_valid && inst_ready;
   assign inst            = fifo_inst[rd_ptr];
   assign inst_pc         = fifo_pc[rd_ptr];
   assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

   always_ff @(posedge clk) begin
      if (!rst) begin
         fpc         <= RESET_PC;
         rpc         <= RESET_PC;
         count       <= '0;
         outstanding <= '0;
         drop        <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else if (redirect) begin
         // Anything still in flight after this cycle belongs to the old stream.
         fpc         <= redirect_pc;
         rpc         <= redirect_pc;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         outstanding <= outstanding_nxt;
         drop        <= outstanding_nxt;
      end else begin
         outstanding <= outstanding_nxt;
         count       <= count + CW'(push) - CW'(pop);
         if (req_fire) begin
            fpc <= fpc + STEP;
         end
         if (imem_rsp_valid && (drop != '0)) begin
            drop <= drop - CW'(1);
         end
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
            rpc    <= rpc + STEP;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_inst[wr_ptr] <= imem_rsp_data;
         fifo_pc[wr_ptr]   <= rpc;
      end
   end

`ifdef YSYX_IFU_MISALIGN_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         halted <= |RESET_PC[1:0];
      end else if (redirect) begin
         halted <= |redirect_pc[1:0];
      end
   end
   assign misalign = rst && halted;
`else
   assign halted   = 1'b0;
   assign misalign = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_ifu_fetch.sv
`default_nettype none
// Testbench for ysyx_ifu_fetch: directed vector table plus scoreboarded
// multi-cycle sequences driven by a small in-order memory model.
module tb_ysyx_ifu_fetch;
   localparam logic [31:0] B = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        misalign;

   ysyx_ifu_fetch #(
      .XLEN(32), .ILEN(32), .DEPTH(4), .RESET_PC(32'h8000_0000)
   ) dut (
      .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid),
      .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
      .misalign(misalign)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rst_n;
      bit          req_ready;
      bit          rsp_valid;
      logic [31:0] rsp_pc;
      bit          inst_ready;
      bit          e_req_valid;
      logic [31:0] e_req_addr;
      bit          e_inst_valid;
      logic [31:0] e_inst_pc;
   } vec_t;

   vec_t        vt[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] pend_addr[$];
   int          pend_due[$];
   int          cyc = 0;
   int          lat = 1;
   int          bench_out = 0;
   int          nfire = 0;
   int          nd = 0;
   logic [31:0] exp_pc = B;
   bit          saw100 = 1'b0;

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   function automatic void av(bit r, bit rr, bit rv, logic [31:0] rp, bit ir,
                              bit erv, logic [31:0] ea, bit eiv, logic [31:0] ep);
      vec_t v;
      v.rst_n = r; v.req_ready = rr; v.rsp_valid = rv; v.rsp_pc = rp; v.inst_ready = ir;
      v.e_req_valid = erv; v.e_req_addr = ea; v.e_inst_valid = eiv; v.e_inst_pc = ep;
      vt.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      @(posedge clk); #1;
      rst = v.rst_n; imem_req_ready = v.req_ready; imem_rsp_valid = v.rsp_valid;
      imem_rsp_data = mdata(v.rsp_pc); inst_ready = v.inst_ready; redirect = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d req_valid", idx), imem_req_valid, v.e_req_valid);
      if (v.e_req_valid) chk($sformatf("vec%0d req_addr", idx), imem_req_addr, v.e_req_addr);
      chk($sformatf("vec%0d inst_valid", idx), inst_valid, v.e_inst_valid);
      if (v.e_inst_valid) begin
         chk($sformatf("vec%0d inst_pc", idx), inst_pc, v.e_inst_pc);
         chk($sformatf("vec%0d inst", idx), inst, mdata(v.e_inst_pc));
      end
      chk($sformatf("vec%0d misalign", idx), misalign, 1'b0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b0; redirect = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1;
      @(negedge clk);
      pend_addr.delete(); pend_due.delete();
      bench_out = 0; nfire = 0; nd = 0; exp_pc = B; saw100 = 1'b0;
   endtask

   // One cycle with the memory model answering in order after lat cycles.
   task automatic step_model(input bit redir, input logic [31:0] tgt, input bit ir);
      @(posedge clk); #1;
      cyc++;
      rst = 1'b1; imem_req_ready = 1'b1; inst_ready = ir; redirect = redir; redirect_pc = tgt;
      imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      if (pend_due.size() > 0 && pend_due[0] == cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mdata(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end
      @(negedge clk);
      if (imem_rsp_valid) begin
         if (bench_out == 0) begin
            n_bad++;
            $display("FAIL rsp_overrun: response with %0d outstanding", bench_out);
         end else begin
            bench_out--;
         end
      end
      if (imem_req_valid && imem_req_ready) begin
         pend_addr.push_back(imem_req_addr);
         pend_due.push_back(cyc + lat);
         bench_out++; nfire++;
         if (imem_req_addr[31:4] == 28'h000_0010) saw100 = 1'b1;
      end
      if (inst_valid && inst_ready) begin
         chk("sb inst_pc", inst_pc, exp_pc);
         chk("sb inst", inst, mdata(exp_pc));
         exp_pc += 32'd4;
         nd++;
      end
      if (redir) begin
         exp_pc = tgt;
         nd = 0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b0;
      do_reset();
      do_reset();

      // Streaming with 1-cycle memory and an always-ready consumer.
      av(0,1,0,0,     1, 0,0,      0,0);
      av(1,1,0,0,     1, 1,B,      0,0);
      av(1,1,1,B,     1, 1,B+4,    0,0);
      av(1,1,1,B+4,   1, 1,B+8,    1,B);
      av(1,1,1,B+8,   1, 1,B+12,   1,B+4);
      av(1,1,1,B+12,  1, 1,B+16,   1,B+8);
      av(1,1,1,B+16,  1, 1,B+20,   1,B+12);
      // Stalled consumer: four credits, then drain in order and resume.
      av(0,1,0,0,     0, 0,0,      0,0);
      av(1,1,0,0,     0, 1,B,      0,0);
      av(1,1,1,B,     0, 1,B+4,    0,0);
      av(1,1,1,B+4,   0, 1,B+8,    1,B);
      av(1,1,1,B+8,   0, 1,B+12,   1,B);
      av(1,1,1,B+12,  0, 0,0,      1,B);
      av(1,1,0,0,     0, 0,0,      1,B);
      av(1,1,0,0,     1, 0,0,      1,B);
      av(1,1,0,0,     1, 1,B+16,   1,B+4);
      av(1,1,1,B+16,  1, 1,B+20,   1,B+8);
      av(1,1,1,B+20,  1, 1,B+24,   1,B+12);
      av(1,1,1,B+24,  1, 1,B+28,   1,B+16);
      for (int i = 0; i < vt.size(); i++) run_vec(vt[i], i);

      // Redirect with three requests in flight.
      do_reset(); lat = 3;
      repeat (3) step_model(1'b0, '0, 1'b1);
      chk("t3 outstanding", bench_out, 3);
      step_model(1'b1, 32'h8000_1000, 1'b1);
      chk("t3 redirect req_valid", imem_req_valid, 1'b0);
      step_model(1'b0, '0, 1'b1);
      chk("t3 restart valid", imem_req_valid, 1'b1);
      chk("t3 restart addr", imem_req_addr, 32'h8000_1000);
      chk("t3 flushed", inst_valid, 1'b0);
      repeat (20) step_model(1'b0, '0, 1'b1);
      chk("t3 delivered", nd >= 8, 1'b1);

      // Full FIFO stall, then push and pop overlapping with a bursty consumer.
      do_reset(); lat = 1;
      repeat (8) step_model(1'b0, '0, 1'b0);
      chk("t4 fires while stalled", nfire, 4);
      chk("t4 credit stop", imem_req_valid, 1'b0);
      chk("t4 head pc", inst_pc, B);
      for (int i = 0; i < 30; i++) step_model(1'b0, '0, (i % 3) != 2);
      chk("t4 delivered", nd >= 15, 1'b1);

      // Back-to-back redirects with two requests in flight.
      do_reset(); lat = 3;
      repeat (2) step_model(1'b0, '0, 1'b1);
      step_model(1'b1, 32'h0000_0100, 1'b1);
      chk("t5 redirect1 req_valid", imem_req_valid, 1'b0);
      step_model(1'b1, 32'h0000_0200, 1'b1);
      chk("t5 redirect2 req_valid", imem_req_valid, 1'b0);
      step_model(1'b0, '0, 1'b1);
      chk("t5 restart addr", imem_req_addr, 32'h0000_0200);
      chk("t5 flushed", inst_valid, 1'b0);
      repeat (20) step_model(1'b0, '0, 1'b1);
      chk("t5 delivered", nd >= 8, 1'b1);
      chk("t5 no fetch at 0x100", saw100, 1'b0);

`ifdef YSYX_IFU_MISALIGN_EN
      do_reset(); lat = 1;
      repeat (3) step_model(1'b0, '0, 1'b1);
      step_model(1'b1, 32'h8000_0002, 1'b1);
      step_model(1'b0, '0, 1'b1);
      chk("t6 misalign set", misalign, 1'b1);
      chk("t6 halted req_valid", imem_req_valid, 1'b0);
      repeat (4) step_model(1'b0, '0, 1'b1);
      chk("t6 still halted", imem_req_valid, 1'b0);
      chk("t6 nothing delivered", inst_valid, 1'b0);
      step_model(1'b1, 32'h8000_0008, 1'b1);
      step_model(1'b0, '0, 1'b1);
      chk("t6 misalign clear", misalign, 1'b0);
      chk("t6 resume valid", imem_req_valid, 1'b1);
      chk("t6 resume addr", imem_req_addr, 32'h8000_0008);
      repeat (6) step_model(1'b0, '0, 1'b1);
      chk("t6 delivered", nd >= 3, 1'b1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
